// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - staged reset release gated by a filtered, synchronised PLL lock
module reset_sequencer #(
  parameter int WAIT_BITS   = 20,
  parameter int NUM_STAGES  = 3,
  parameter int STAGE_GAP   = 16,
  parameter int LOCK_FILTER = 4
) (
  input  logic                  sysclk,
  input  logic                  reset_n,
  input  logic                  pll_locked,
  input  logic                  sw_reset_req,
  input  logic                  clr_sticky,
  output logic [NUM_STAGES-1:0] rst_out_n,
  output logic                  all_ready,
  output logic                  lock_lost
);

  typedef enum logic [1:0] {WAIT_LOCK, SETTLE, RELEASE, RUN} state_e;

  localparam logic [3:0]           FILT_LAST   = 4'(LOCK_FILTER - 1);
  localparam logic [7:0]           GAP_LAST    = 8'(STAGE_GAP - 1);
  localparam logic [WAIT_BITS-1:0] SETTLE_LAST = '1;

  state_e                state_q, state_d;
  logic [1:0]            sync_q;
  logic [3:0]            filt_q, filt_d;
  logic [WAIT_BITS-1:0]  settle_q, settle_d;
  logic [7:0]            gap_q, gap_d;
  logic [NUM_STAGES-1:0] rst_q, rst_d;
  logic                  ready_q, ready_d;
  logic                  lost_q, lost_d;
  logic                  lk_s;
  logic [NUM_STAGES:0]   shifted;

  assign lk_s    = sync_q[1];
  // Thermometer shift: releasing the next stage can never re-assert an earlier one.
  assign shifted = {rst_q, 1'b1};

  always_comb begin
    state_d  = state_q;
    filt_d   = filt_q;
    settle_d = settle_q;
    gap_d    = gap_q;
    rst_d    = rst_q;
    ready_d  = ready_q;
    lost_d   = clr_sticky ? 1'b0 : lost_q;

    if (state_q != WAIT_LOCK && !lk_s) begin
      state_d  = WAIT_LOCK;
      filt_d   = '0;
      settle_d = '0;
      gap_d    = '0;
      rst_d    = '0;
      ready_d  = 1'b0;
      lost_d   = 1'b1;
    end else begin
      case (state_q)
        WAIT_LOCK: begin
          if (!lk_s) begin
            filt_d = '0;
          end else if (filt_q == FILT_LAST) begin
            filt_d   = '0;
            settle_d = '0;
            state_d  = SETTLE;
          end else begin
            filt_d = filt_q + 4'd1;
          end
        end
        SETTLE: begin
          if (settle_q == SETTLE_LAST) begin
            settle_d = '0;
            gap_d    = '0;
            rst_d    = NUM_STAGES'(1);
            ready_d  = rst_d[NUM_STAGES-1];
            state_d  = rst_d[NUM_STAGES-1] ? RUN : RELEASE;
          end else begin
            settle_d = settle_q + 1'b1;
          end
        end
        RELEASE, RUN: begin
          if (sw_reset_req) begin
            rst_d    = '0;
            ready_d  = 1'b0;
            settle_d = '0;
            gap_d    = '0;
            state_d  = SETTLE;
          end else if (state_q == RELEASE) begin
            if (gap_q == GAP_LAST) begin
              gap_d = '0;
              rst_d = shifted[NUM_STAGES-1:0];
              if (rst_d[NUM_STAGES-1]) begin
                ready_d = 1'b1;
                state_d = RUN;
              end
            end else begin
              gap_d = gap_q + 8'd1;
            end
          end
        end
        default: state_d = WAIT_LOCK;
      endcase
    end
  end

  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= WAIT_LOCK;
      sync_q   <= '0;
      filt_q   <= '0;
      settle_q <= '0;
      gap_q    <= '0;
      rst_q    <= '0;
      ready_q  <= 1'b0;
      lost_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sync_q   <= {sync_q[0], pll_locked};
      filt_q   <= filt_d;
      settle_q <= settle_d;
      gap_q    <= gap_d;
      rst_q    <= rst_d;
      ready_q  <= ready_d;
      lost_q   <= lost_d;
    end
  end

  assign rst_out_n = rst_q;
  assign all_ready = ready_q;
  assign lock_lost = lost_q;

endmodule
